// File: rtl/adc_serial_responder.sv
// adc_serial_responder: system-clock-domain slave model of an LTC2308-style
// serial ADC port. Answers CS_N/SCLK/DIN frames with 12-bit samples picked
// from eight internal channel inputs. The configuration is pipelined: each
// frame returns data for the config latched at the end of the previous one.
//
// Optional feature macro: ADC_RESP_BIPOLAR_EN
//   defined   -> UNI=0 returns the sample with its MSB inverted
//                (two's-complement view)
//   undefined -> UNI is ignored and the raw sample is always returned
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | CS_N high, ADC_DOUT=0, waiting for a CS_N falling edge
// SHIFT | frame active, DIN captured on SCLK rise, DOUT advanced on fall
// TAIL  | all data bits sent, ADC_DOUT=0, SCLK ignored until CS_N rises
//
// SYNC_STAGES must be at least 2.

module adc_serial_responder #(
  parameter int DATA_WIDTH  = 12,
  parameter int CFG_BITS    = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [8*DATA_WIDTH-1:0] chData,
  input  logic                    ADC_CS_N,
  input  logic                    ADC_SCLK,
  input  logic                    ADC_DIN,
  output logic                    ADC_DOUT,
  output logic                    frameDone,
  output logic                    frameError,
  output logic [2:0]              lastChannel
);

  localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int CFG_CNT_W = $clog2(CFG_BITS + 1);

  // Only the config bits that affect the returned data are kept:
  // {S/D, O/S, S1, S0} plus UNI when the bipolar view is built in.
`ifdef ADC_RESP_BIPOLAR_EN
  localparam int ACT_W = 5;
`else
  localparam int ACT_W = 4;
`endif
  localparam logic [4:0]      CFG_RESET_FULL = 5'b10001;
  localparam logic [ACT_W-1:0] CFG_RESET     = CFG_RESET_FULL[4 -: ACT_W];

  typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  cs_sync, sclk_sync, din_sync;
  logic                    cs_q, sclk_q;
  logic                    cs_fall, cs_rise, sclk_rise, sclk_fall, din_s;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic [BIT_CNT_W-1:0]    bits_left;
  logic [CFG_CNT_W-1:0]    cfg_left;
  logic [CFG_BITS-1:0]     cfg_shift;
  logic [ACT_W-1:0]        cfg_act;
  logic [2:0]              sel_ch;
  logic                    sel_single;
  logic [DATA_WIDTH-1:0]   raw, sample;

  // Synchronize the serial inputs; the extra _q flop gives the edge reference.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      din_sync  <= '0;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], ADC_CS_N};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], ADC_SCLK};
      din_sync  <= {din_sync[SYNC_STAGES-2:0], ADC_DIN};
      cs_q      <= cs_sync[SYNC_STAGES-1];
      sclk_q    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign cs_fall   =  cs_q   & ~cs_sync[SYNC_STAGES-1];
  assign cs_rise   = ~cs_q   &  cs_sync[SYNC_STAGES-1];
  assign sclk_rise = ~sclk_q &  sclk_sync[SYNC_STAGES-1];
  assign sclk_fall =  sclk_q & ~sclk_sync[SYNC_STAGES-1];
  assign din_s     =  din_sync[SYNC_STAGES-1];

  // Single-ended channel number is {S1, S0, O/S}.
  assign sel_single = cfg_act[ACT_W-1];
  assign sel_ch     = {cfg_act[ACT_W-3], cfg_act[ACT_W-4], cfg_act[ACT_W-2]};

  // Select the sample for the active config; differential mode returns zero.
  always_comb begin
    raw = '0;
    for (int i = 0; i < 8; i++) begin
      if (sel_ch == 3'(i)) raw = chData[i*DATA_WIDTH +: DATA_WIDTH];
    end
    sample = '0;
    if (sel_single) begin
`ifdef ADC_RESP_BIPOLAR_EN
      if (!cfg_act[0]) sample = raw ^ {1'b1, {(DATA_WIDTH-1){1'b0}}};
      else             sample = raw;
`else
      sample = raw;
`endif
    end
  end

  // Frame FSM: shift-out on SCLK fall, config capture on SCLK rise, CS_N rise
  // takes priority over any SCLK edge in the same clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      shift_reg   <= '0;
      bits_left   <= '0;
      cfg_left    <= '0;
      cfg_shift   <= '0;
      cfg_act     <= CFG_RESET;
      ADC_DOUT    <= 1'b0;
      frameDone   <= 1'b0;
      frameError  <= 1'b0;
      lastChannel <= '0;
    end else begin
      frameDone  <= 1'b0;
      frameError <= 1'b0;
      if (state != IDLE && cs_rise) begin
        state    <= IDLE;
        ADC_DOUT <= 1'b0;
        if (state == TAIL && cfg_left == '0) begin
          cfg_act     <= cfg_shift[CFG_BITS-1 -: ACT_W];
          lastChannel <= sel_ch;
          frameDone   <= 1'b1;
        end else begin
          frameError  <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              shift_reg <= sample;
              ADC_DOUT  <= sample[DATA_WIDTH-1];
              bits_left <= BIT_CNT_W'(DATA_WIDTH);
              cfg_left  <= CFG_CNT_W'(CFG_BITS);
              state     <= SHIFT;
            end
          end
          SHIFT: begin
            if (sclk_rise && cfg_left != '0) begin
              cfg_shift <= {cfg_shift[CFG_BITS-2:0], din_s};
              cfg_left  <= cfg_left - 1'b1;
            end
            if (sclk_fall) begin
              if (bits_left == BIT_CNT_W'(1)) begin
                bits_left <= '0;
                ADC_DOUT  <= 1'b0;
                state     <= TAIL;
              end else begin
                bits_left <= bits_left - 1'b1;
                ADC_DOUT  <= shift_reg[DATA_WIDTH-2];
                shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
              end
            end
          end
          TAIL: begin
            ADC_DOUT <= 1'b0;
          end
          default: begin
            state    <= IDLE;
            ADC_DOUT <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_serial_responder.sv
// Self-checking bench for adc_serial_responder: directed frames from the
// test plan followed by randomized frames, checked against a frame-level
// reference model (latched config, channel array, pulse expectations).
// Honours ADC_RESP_BIPOLAR_EN in the same way the design does.

module tb_adc_serial_responder;

  localparam int LAT = 3;  // SYNC_STAGES + 1

  logic        clock = 1'b0;
  logic        reset_n;
  logic [95:0] chData;
  logic        ADC_CS_N, ADC_SCLK, ADC_DIN;
  logic        ADC_DOUT, frameDone, frameError;
  logic [2:0]  lastChannel;

  logic [11:0] ch_arr [8];
  logic [5:0]  ref_cfg;
  int          ref_last;
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;

  adc_serial_responder #(.DATA_WIDTH(12), .CFG_BITS(6), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset_n(reset_n), .chData(chData),
    .ADC_CS_N(ADC_CS_N), .ADC_SCLK(ADC_SCLK), .ADC_DIN(ADC_DIN),
    .ADC_DOUT(ADC_DOUT), .frameDone(frameDone), .frameError(frameError),
    .lastChannel(lastChannel)
  );

  always #5 clock = ~clock;

  always_comb begin
    for (int i = 0; i < 8; i++) chData[i*12 +: 12] = ch_arr[i];
  end

  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if (frameDone)  done_cnt++;
      if (frameError) err_cnt++;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Reference: channel = 4*S1 + 2*S0 + O/S, zero in differential mode.
  function automatic int ref_channel(input logic [5:0] cfg);
    return 4*int'(cfg[3]) + 2*int'(cfg[2]) + int'(cfg[4]);
  endfunction

  function automatic logic [11:0] ref_sample(input logic [5:0] cfg);
    logic [11:0] v;
    if (!cfg[5]) return 12'h000;
    v = ch_arr[ref_channel(cfg)];
`ifdef ADC_RESP_BIPOLAR_EN
    if (!cfg[1]) v = v ^ 12'h800;
`endif
    return v;
  endfunction

  // One complete frame of nsclk SCLK pulses; checks data, tail, pulses,
  // pulse latency and lastChannel against the model, then updates the model.
  task automatic do_frame(input string tag, input logic [5:0] cfg, input int nsclk);
    logic [15:0] got, exp_bits, mask;
    logic [11:0] exp12;
    int          d0, e0, lat;
    bit          valid;
    exp12    = ref_sample(ref_cfg);
    valid    = (nsclk >= 12);
    exp_bits = {exp12, 4'b0000};
    mask     = ~(16'hFFFF >> nsclk);
    got      = '0;
    d0 = done_cnt;
    e0 = err_cnt;
    ADC_CS_N = 1'b0;
    tick(6);
    for (int i = 0; i < nsclk; i++) begin
      ADC_DIN = (i < 6) ? cfg[5-i] : 1'($urandom_range(0, 1));
      tick(4);
      if (i < 16) got[15-i] = ADC_DOUT;
      ADC_SCLK = 1'b1;
      tick(4);
      ADC_SCLK = 1'b0;
    end
    tick(4);
    ADC_CS_N = 1'b1;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      if ((frameDone || frameError) && lat == 0) lat = k;
    end
    check_val({tag, "_data"}, 32'(got), 32'(exp_bits & mask));
    check_val({tag, "_done"}, 32'(done_cnt - d0), valid ? 32'd1 : 32'd0);
    check_val({tag, "_err"},  32'(err_cnt - e0),  valid ? 32'd0 : 32'd1);
    check_val({tag, "_lat"},  32'(lat), 32'(LAT));
    if (valid) begin
      ref_last = ref_channel(ref_cfg);
      ref_cfg  = cfg;
    end
    check_val({tag, "_last"}, 32'(lastChannel), 32'(ref_last));
    check_val({tag, "_dout_idle"}, 32'(ADC_DOUT), 32'd0);
  endtask

  initial begin
    int d0, e0, dout_hi;
    logic [5:0]  rcfg;
    int          rn;
    reset_n  = 1'b0;
    ADC_CS_N = 1'b1;
    ADC_SCLK = 1'b0;
    ADC_DIN  = 1'b0;
    for (int i = 0; i < 8; i++) ch_arr[i] = 12'h000;
    ref_cfg  = 6'b100010;
    ref_last = 0;
    tick(3);
    check_val("rst_dout",  32'(ADC_DOUT),    32'd0);
    check_val("rst_done",  32'(frameDone),   32'd0);
    check_val("rst_err",   32'(frameError),  32'd0);
    check_val("rst_last",  32'(lastChannel), 32'd0);
    reset_n = 1'b1;
    tick(4);

    // Basic frame after reset.
    ch_arr[0] = 12'hABC;
    ch_arr[7] = 12'h123;
    do_frame("basic", 6'b100010, 12);

    // Pipelining: config for CH7 takes effect on the following frame.
    do_frame("pipe1", 6'b111110, 12);
    do_frame("pipe2", 6'b100010, 12);

    // Bipolar view of CH0 = 0.
    ch_arr[0] = 12'h000;
    do_frame("bip1", 6'b100000, 12);
    do_frame("bip2", 6'b111110, 12);

    // Abort after 3 SCLKs keeps the previous config.
    ch_arr[5] = 12'h5C3;
    do_frame("abort", 6'b110110, 3);
    do_frame("after_abort", 6'b110110, 12);
    do_frame("chk5", 6'b100010, 12);

    // 16 SCLKs: bits 13-16 read as zero.
    ch_arr[0] = 12'hFFF;
    do_frame("tail", 6'b100010, 16);

    // SCLK/DIN noise while CS_N is high.
    d0 = done_cnt; e0 = err_cnt; dout_hi = 0;
    for (int i = 0; i < 20; i++) begin
      ADC_SCLK = ~ADC_SCLK;
      ADC_DIN  = 1'($urandom_range(0, 1));
      tick(2);
      if (ADC_DOUT !== 1'b0) dout_hi++;
    end
    ADC_SCLK = 1'b0;
    tick(6);
    check_val("noise_dout", 32'(dout_hi), 32'd0);
    check_val("noise_done", 32'(done_cnt - d0), 32'd0);
    check_val("noise_err",  32'(err_cnt - e0),  32'd0);

    // Reset mid-frame: switch to CH7 first so the reset visibly changes config.
    do_frame("pre_rst", 6'b111110, 12);
    for (int i = 0; i < 8; i++) ch_arr[i] = 12'hFFF;
    d0 = done_cnt; e0 = err_cnt;
    ADC_CS_N = 1'b0;
    tick(6);
    for (int i = 0; i < 5; i++) begin
      tick(4);
      ADC_SCLK = 1'b1;
      tick(4);
      ADC_SCLK = 1'b0;
    end
    tick(4);
    check_val("mid_dout_before", 32'(ADC_DOUT), 32'd1);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 check_val("mid_dout_async", 32'(ADC_DOUT), 32'd0);
    ADC_CS_N = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(8);
    check_val("mid_done", 32'(done_cnt - d0), 32'd0);
    check_val("mid_err",  32'(err_cnt - e0),  32'd0);
    check_val("mid_last", 32'(lastChannel), 32'd0);
    ref_cfg  = 6'b100010;
    ref_last = 0;
    ch_arr[0] = 12'h5A5;
    do_frame("post_rst", 6'b101010, 12);

    // Randomized frames.
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 8; i++) ch_arr[i] = 12'($urandom);
      rcfg = 6'($urandom);
      if ($urandom_range(0, 3) == 0) rn = $urandom_range(1, 11);
      else                           rn = $urandom_range(12, 16);
      do_frame($sformatf("rnd%0d", n), rcfg, rn);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
